// File: rtl/ecc_pkg.sv
// Shared SECDED definitions for the 64+16 encoder/decoder pair: sizes, the
// per-data-bit check column, and the decoded result record.
package ecc_pkg;

  localparam int DATA_W = 64;
  localparam int CHK_W  = 16;
  localparam int CODE_W = 80;
  localparam logic [6:0] POS_NONE = 7'd127;

  // Column for data bit b: upper byte is the complement of the lower byte.
  // This keeps every data column at weight 8, distinct from the one-hot check columns.
  function automatic logic [CHK_W-1:0] col(input logic [7:0] b);
    return {~b, b};
  endfunction

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              corrected;
    logic              uncorrectable;
    logic [6:0]        pos;
  } ecc_result_t;

endpackage

// File: rtl/ecc_syndrome_calc.sv
// Combinational syndrome: check bits XOR the columns of every set data bit.
// The encoder reuses this block with the check-bit field tied to zero.
module ecc_syndrome_calc
  import ecc_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [CHK_W-1:0]  syndrome
);

  logic [CHK_W-1:0] term [DATA_W];

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_term
      assign term[gi] = code[gi] ? col(8'(gi)) : '0;
    end
  endgenerate

  always_comb begin
    syndrome = code[CODE_W-1:DATA_W];
    for (int i = 0; i < DATA_W; i++) begin
      syndrome = syndrome ^ term[i];
    end
  end

endmodule

// File: rtl/ecc_secded_decoder.sv
// Two-stage SECDED decoder with valid/ready on both sides.
// Statistics counters exist only when ECC_STATS_EN is defined.
module ecc_secded_decoder
  import ecc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [79:0]       in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_data,
  output logic              out_corrected,
  output logic              out_uncorrectable,
  output logic [6:0]        out_err_pos,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stat_corr_cnt,
  output logic [CNT_W-1:0]  stat_unc_cnt
);

  localparam ecc_result_t RES_RST = '{data: '0, corrected: 1'b0,
                                      uncorrectable: 1'b0, pos: POS_NONE};

  logic [CHK_W-1:0]  syn_in;
  logic              s2_load;

  // Stage 1 keeps only the data; the syndrome already carries all check-bit information.
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [CHK_W-1:0]  s1_syn_q, s1_syn_d;

  logic              s2_valid_q, s2_valid_d;
  ecc_result_t       s2_res_q, s2_res_d;

  ecc_result_t       corr_res;
  logic [6:0]        chk_pos;

  ecc_syndrome_calc u_syn (
    .code     (in_code),
    .syndrome (syn_in)
  );

  assign s2_load  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;

  always_comb begin
    chk_pos = POS_NONE;
    for (int j = 0; j < CHK_W; j++) begin
      if (s1_syn_q[j]) chk_pos = 7'(DATA_W + j);
    end

    corr_res = '{data: s1_data_q, corrected: 1'b0, uncorrectable: 1'b0, pos: POS_NONE};
    if (s1_syn_q != '0) begin
      if ($onehot(s1_syn_q)) begin
        corr_res.corrected = 1'b1;
        corr_res.pos       = chk_pos;
      end else if (s1_syn_q[15:8] == ~s1_syn_q[7:0] && s1_syn_q[7:6] == 2'b00) begin
        corr_res.data      = s1_data_q ^ (64'd1 << s1_syn_q[5:0]);
        corr_res.corrected = 1'b1;
        corr_res.pos       = {1'b0, s1_syn_q[5:0]};
      end else begin
        corr_res.uncorrectable = 1'b1;
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_syn_d   = s1_syn_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_code[DATA_W-1:0];
        s1_syn_d  = syn_in;
      end
    end

    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_res_d = corr_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_syn_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= RES_RST;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_syn_q   <= s1_syn_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
    end
  end

  assign out_valid         = s2_valid_q;
  assign out_data          = s2_res_q.data;
  assign out_corrected     = s2_res_q.corrected;
  assign out_uncorrectable = s2_res_q.uncorrectable;
  assign out_err_pos       = s2_res_q.pos;

`ifdef ECC_STATS_EN
  logic             out_fire;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] unc_cnt_q, unc_cnt_d;

  assign out_fire = s2_valid_q && out_ready;

  // Clear wins over a same-cycle increment.
  always_comb begin
    corr_cnt_d = corr_cnt_q;
    unc_cnt_d  = unc_cnt_q;
    if (stat_clr) begin
      corr_cnt_d = '0;
      unc_cnt_d  = '0;
    end else if (out_fire) begin
      if (s2_res_q.corrected && !(&corr_cnt_q))   corr_cnt_d = corr_cnt_q + CNT_W'(1);
      if (s2_res_q.uncorrectable && !(&unc_cnt_q)) unc_cnt_d = unc_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q <= '0;
      unc_cnt_q  <= '0;
    end else begin
      corr_cnt_q <= corr_cnt_d;
      unc_cnt_q  <= unc_cnt_d;
    end
  end

  assign stat_corr_cnt = corr_cnt_q;
  assign stat_unc_cnt  = unc_cnt_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_corr_cnt   = '0;
  assign stat_unc_cnt    = '0;
`endif

endmodule

// File: tb/tb_ecc_secded_decoder.sv
// Directed bench for ecc_secded_decoder (CNT_W = 4); counter expectations follow ECC_STATS_EN.
module tb_ecc_secded_decoder;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = 15;
`ifdef ECC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [63:0] W0 = 64'h0123_4567_89AB_CDEF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [79:0]      in_code = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [63:0]      out_data;
  logic             out_corrected;
  logic             out_uncorrectable;
  logic [6:0]       out_err_pos;
  logic             stat_clr = 1'b0;
  logic [CNT_W-1:0] stat_corr_cnt;
  logic [CNT_W-1:0] stat_unc_cnt;

  int total = 0;
  int bad = 0;
  int exp_corr = 0;
  int exp_unc = 0;

  always #5 clk = ~clk;

  ecc_secded_decoder #(.CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_code           (in_code),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_corrected     (out_corrected),
    .out_uncorrectable (out_uncorrectable),
    .out_err_pos       (out_err_pos),
    .stat_clr          (stat_clr),
    .stat_corr_cnt     (stat_corr_cnt),
    .stat_unc_cnt      (stat_unc_cnt)
  );

  // Reference encoder straight from the code definition.
  function automatic logic [79:0] enc(input logic [63:0] d);
    logic [15:0] chk;
    logic [7:0]  b;
    chk = '0;
    for (int i = 0; i < 64; i++) begin
      b = 8'(i);
      if (d[i]) chk = chk ^ {~b, b};
    end
    return {chk, d};
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : CNT_MAX;
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt(input int v);
    return STATS ? CNT_W'(v) : '0;
  endfunction

  // Sends one word with out_ready high and waits (bounded) for its result.
  task automatic send_recv(input logic [79:0] code, input logic clr,
                           output logic [63:0] d, output logic c, output logic u,
                           output logic [6:0] p, output int lat, output logic ok);
    in_valid  = 1'b1;
    in_code   = code;
    out_ready = 1'b1;
    stat_clr  = 1'b0;
    @(negedge clk);
    ok = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (lat < 10) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    d = out_data; c = out_corrected; u = out_uncorrectable; p = out_err_pos;
    if (!out_valid) ok = 1'b0;
    stat_clr = clr;
    @(posedge clk); #1;
    stat_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stat_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 64'd0 || out_corrected !== 1'b0 ||
        out_uncorrectable !== 1'b0 || out_err_pos !== 7'd127) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b data=%h corr=%b unc=%b pos=%0d, want 0/0/0/0/127",
               out_valid, out_data, out_corrected, out_uncorrectable, out_err_pos);
    end
    total++;
    if (stat_corr_cnt !== '0 || stat_unc_cnt !== '0) begin
      bad++;
      $display("FAIL reset_counters: corr=%0d unc=%0d, want 0/0", stat_corr_cnt, stat_unc_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_clean();
    logic [63:0] d; logic c, u, ok; logic [6:0] p; int lat;
    send_recv(enc(W0), 1'b0, d, c, u, p, lat, ok);
    total++;
    if (!ok || d !== W0 || c !== 1'b0 || u !== 1'b0 || p !== 7'd127 || lat != 2) begin
      bad++;
      $display("FAIL clean: ok=%b data=%h corr=%b unc=%b pos=%0d lat=%0d, want data=%h 0/0/127 lat=2",
               ok, d, c, u, p, lat, W0);
    end
    total++;
    if (stat_corr_cnt !== exp_cnt(exp_corr) || stat_unc_cnt !== exp_cnt(exp_unc)) begin
      bad++;
      $display("FAIL clean_counters: corr=%0d unc=%0d want %0d/%0d",
               stat_corr_cnt, stat_unc_cnt, exp_cnt(exp_corr), exp_cnt(exp_unc));
    end
  endtask

  task automatic test_single_error();
    logic [63:0] d; logic c, u, ok; logic [6:0] p; int lat;
    send_recv(enc(W0) ^ (80'd1 << 5), 1'b0, d, c, u, p, lat, ok);
    exp_corr = sat_inc(exp_corr);
    total++;
    if (!ok || d !== W0 || c !== 1'b1 || u !== 1'b0 || p !== 7'd5) begin
      bad++;
      $display("FAIL single_bit5: data=%h corr=%b unc=%b pos=%0d, want %h 1/0/5", d, c, u, p, W0);
    end
    total++;
    if (stat_corr_cnt !== exp_cnt(exp_corr)) begin
      bad++;
      $display("FAIL single_bit5_count: corr=%0d want %0d", stat_corr_cnt, exp_cnt(exp_corr));
    end
    for (int k = 0; k < 80; k++) begin
      send_recv(enc(W0) ^ (80'd1 << k), 1'b0, d, c, u, p, lat, ok);
      exp_corr = sat_inc(exp_corr);
      total++;
      if (!ok || d !== W0 || c !== 1'b1 || u !== 1'b0 || p !== 7'(k) || lat != 2) begin
        bad++;
        $display("FAIL sweep_bit%0d: data=%h corr=%b unc=%b pos=%0d lat=%0d, want %h 1/0/%0d lat=2",
                 k, d, c, u, p, lat, W0, k);
      end
    end
    total++;
    if (stat_corr_cnt !== exp_cnt(exp_corr) || stat_unc_cnt !== exp_cnt(exp_unc)) begin
      bad++;
      $display("FAIL sweep_counters: corr=%0d unc=%0d want %0d/%0d",
               stat_corr_cnt, stat_unc_cnt, exp_cnt(exp_corr), exp_cnt(exp_unc));
    end
  endtask

  task automatic test_double_error();
    logic [63:0] d; logic c, u, ok; logic [6:0] p; int lat;
    logic [63:0] bad_data;
    bad_data = W0 ^ (64'd1 << 3) ^ (64'd1 << 40);
    send_recv(enc(W0) ^ (80'd1 << 3) ^ (80'd1 << 40), 1'b0, d, c, u, p, lat, ok);
    exp_unc = sat_inc(exp_unc);
    total++;
    if (!ok || d !== bad_data || c !== 1'b0 || u !== 1'b1 || p !== 7'd127) begin
      bad++;
      $display("FAIL double_3_40: data=%h corr=%b unc=%b pos=%0d, want %h 0/1/127",
               d, c, u, p, bad_data);
    end
    total++;
    if (stat_unc_cnt !== exp_cnt(exp_unc) || stat_corr_cnt !== exp_cnt(exp_corr)) begin
      bad++;
      $display("FAIL double_counters: unc=%0d corr=%0d want %0d/%0d",
               stat_unc_cnt, stat_corr_cnt, exp_cnt(exp_unc), exp_cnt(exp_corr));
    end
    // Two check-bit flips give a weight-2 syndrome.
    send_recv(enc(W0) ^ (80'd1 << 64) ^ (80'd1 << 79), 1'b0, d, c, u, p, lat, ok);
    exp_unc = sat_inc(exp_unc);
    total++;
    if (!ok || d !== W0 || c !== 1'b0 || u !== 1'b1 || p !== 7'd127) begin
      bad++;
      $display("FAIL double_chk: data=%h corr=%b unc=%b pos=%0d, want %h 0/1/127", d, c, u, p, W0);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] words [4];
    logic [63:0] held;
    logic        held_v;
    int sent, got, first_block;
    words[0] = 64'h1111_2222_3333_4444;
    words[1] = 64'hDEAD_BEEF_0000_FFFF;
    words[2] = 64'h8000_0000_0000_0001;
    words[3] = 64'h5A5A_A5A5_F0F0_0F0F;
    sent = 0; got = 0; first_block = -1; held_v = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      in_valid  = (sent < 4);
      in_code   = enc(words[(sent < 4) ? sent : 3]);
      out_ready = (cyc >= 3);
      @(negedge clk);
      if (held_v) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          bad++;
          $display("FAIL bp_hold: valid=%b data=%h, want 1/%h", out_valid, out_data, held);
        end
      end
      if (in_valid && in_ready) sent++;
      else if (in_valid && !in_ready && first_block < 0) first_block = sent;
      if (out_valid && out_ready) begin
        total++;
        if (out_data !== words[got] || out_corrected !== 1'b0) begin
          bad++;
          $display("FAIL bp_order%0d: data=%h corr=%b, want %h/0", got, out_data, out_corrected, words[got]);
        end
        got++;
        held_v = 1'b0;
      end else begin
        held_v = out_valid;
        held   = out_data;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (got != 4 || sent != 4) begin
      bad++;
      $display("FAIL bp_count: sent=%0d got=%0d, want 4/4", sent, got);
    end
    total++;
    if (first_block != 2) begin
      bad++;
      $display("FAIL bp_in_ready: blocked after %0d words, want 2", first_block);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d; logic c, u, ok; logic [6:0] p; int lat;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = enc(64'hAAAA_0000_BBBB_0000);
    @(posedge clk); #1;
    in_code   = enc(64'hCCCC_DDDD_EEEE_FFFF) ^ (80'd1 << 7);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: out_valid=%b want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    exp_corr = 0;
    exp_unc  = 0;
    total++;
    if (out_valid !== 1'b0 || out_err_pos !== 7'd127 || stat_corr_cnt !== '0 || stat_unc_cnt !== '0) begin
      bad++;
      $display("FAIL mid_reset: valid=%b pos=%0d corr=%0d unc=%0d, want 0/127/0/0",
               out_valid, out_err_pos, stat_corr_cnt, stat_unc_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
    send_recv(enc(64'h0F0F_0F0F_0F0F_0F0F), 1'b0, d, c, u, p, lat, ok);
    total++;
    if (!ok || lat != 2 || d !== 64'h0F0F_0F0F_0F0F_0F0F || c !== 1'b0 || u !== 1'b0) begin
      bad++;
      $display("FAIL mid_after: ok=%b lat=%0d data=%h corr=%b unc=%b, want lat=2 data=0f0f.. 0/0",
               ok, lat, d, c, u);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_stale: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_counters();
    logic [63:0] d; logic c, u, ok; logic [6:0] p; int lat;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    exp_corr = 0;
    exp_unc  = 0;
    total++;
    if (stat_corr_cnt !== '0 || stat_unc_cnt !== '0) begin
      bad++;
      $display("FAIL cnt_clr: corr=%0d unc=%0d want 0/0", stat_corr_cnt, stat_unc_cnt);
    end
    for (int k = 0; k < 17; k++) begin
      send_recv(enc(W0) ^ (80'd1 << (k * 3)), 1'b0, d, c, u, p, lat, ok);
      exp_corr = sat_inc(exp_corr);
      if (k == 13 || k == 16) begin
        total++;
        if (stat_corr_cnt !== exp_cnt(exp_corr)) begin
          bad++;
          $display("FAIL cnt_word%0d: corr=%0d want %0d", k + 1, stat_corr_cnt, exp_cnt(exp_corr));
        end
      end
    end
    total++;
    if (stat_corr_cnt !== exp_cnt(CNT_MAX) || stat_unc_cnt !== '0) begin
      bad++;
      $display("FAIL cnt_saturate: corr=%0d unc=%0d want %0d/0", stat_corr_cnt, stat_unc_cnt, exp_cnt(CNT_MAX));
    end
    send_recv(enc(W0) ^ (80'd1 << 3) ^ (80'd1 << 40), 1'b0, d, c, u, p, lat, ok);
    exp_unc = sat_inc(exp_unc);
    total++;
    if (stat_unc_cnt !== exp_cnt(exp_unc)) begin
      bad++;
      $display("FAIL cnt_unc: unc=%0d want %0d", stat_unc_cnt, exp_cnt(exp_unc));
    end
    send_recv(enc(W0) ^ (80'd1 << 70), 1'b1, d, c, u, p, lat, ok);
    exp_corr = 0;
    exp_unc  = 0;
    total++;
    if (stat_corr_cnt !== '0 || stat_unc_cnt !== '0 || c !== 1'b1 || p !== 7'd70) begin
      bad++;
      $display("FAIL cnt_clr_prio: corr=%0d unc=%0d wcorr=%b pos=%0d, want 0/0/1/70",
               stat_corr_cnt, stat_unc_cnt, c, p);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_double_error();
    test_backpressure();
    test_reset_mid();
    test_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
